// File: rtl/rx_session_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_session_ctrl_pkg                                                  |
// | State and status encodings shared by the RX session sequencer.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rx_session_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_LTF = 3'd1,
    ST_WAIT_SIG = 3'd2,
    ST_WAIT_LEN = 3'd3,
    ST_DECODE   = 3'd4,
    ST_WAIT_FCS = 3'd5,
    ST_RST      = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    RX_NONE    = 3'd0,
    RX_OK      = 3'd1,
    RX_FCS_ERR = 3'd2,
    RX_HDR_ERR = 3'd3,
    RX_UNSUPP  = 3'd4,
    RX_TO_LTF  = 3'd5,
    RX_TO_SIG  = 3'd6,
    RX_TO_DATA = 3'd7
  } status_t;

  localparam logic [14:0] c_sym_max = 15'h7FFF;

  function automatic logic [14:0] sym_inc(input logic [14:0] cnt, input logic pulse);
    return (pulse && (cnt != c_sym_max)) ? cnt + 15'd1 : cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_session_ctrl_stage_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_stage_timer                                                       |
// | Saturating sample counter with clear and threshold hit (0 = off).    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rx_stage_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] th,
  output logic             hit
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   w_cnt_next;

  // Hit looks at the count including this cycle's sample so the stage
  // exits on the edge that samples the threshold-reaching strobe.
  assign w_cnt_next = {1'b0, cnt_q} + (CNT_W+1)'(inc);
  assign hit        = (th != '0) && (w_cnt_next >= {1'b0, th});

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_session_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_session_ctrl                                                      |
// | Per-packet RX sequencer: stage tracking, receiver reset, status.     |
// | Optional statistics: define RX_SESSION_CTRL_STAT_EN.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rx_session_ctrl
  import rx_session_ctrl_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int RST_CYC    = 4,
  parameter int SYM_MARGIN = 2,
  parameter int STAT_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrl_enable,
  input  logic              sample_in_strobe,
  input  logic              short_preamble_detected,
  input  logic              long_preamble_detected,
  input  logic              pkt_header_valid_strobe,
  input  logic              pkt_header_valid,
  input  logic              ht_unsupport,
  input  logic              phy_len_valid,
  input  logic [14:0]       n_ofdm_sym,
  input  logic              ofdm_symbol_eq_out_pulse,
  input  logic              fcs_out_strobe,
  input  logic              fcs_ok,
  input  logic [CNT_W-1:0]  ltf_to_th,
  input  logic [CNT_W-1:0]  sig_to_th,
  input  logic [CNT_W-1:0]  fcs_to_th,
  output logic              core_rst,
  output logic              session_active,
  output logic [2:0]        state,
  output logic [14:0]       sym_count,
  output logic              rx_done_strobe,
  output logic [2:0]        rx_status,
  output logic [STAT_W-1:0] stat_ok,
  output logic [STAT_W-1:0] stat_fcs_err,
  output logic [STAT_W-1:0] stat_hdr_err,
  output logic [STAT_W-1:0] stat_timeout
);

  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  state_t         state_q, state_d;
  status_t        status_q, status_d;
  logic           spd_q;
  logic [14:0]    sym_q, sym_d, n_q, n_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic           done_q, done_d, core_rst_q, core_rst_d, active_q, active_d;

  logic             w_start, w_to_hit, w_fail;
  status_t          w_fail_code;
  logic [CNT_W-1:0] w_th;
  logic [14:0]      w_sym_next;
  logic [15:0]      w_sym_lim;

  assign w_start   = short_preamble_detected && !spd_q && ctrl_enable;
  assign w_sym_lim = {1'b0, n_q} + 16'(SYM_MARGIN);

  always_comb begin
    w_th = '0;
    case (state_q)
      ST_WAIT_LTF:              w_th = ltf_to_th;
      ST_WAIT_SIG, ST_WAIT_LEN: w_th = sig_to_th;
      ST_WAIT_FCS:              w_th = fcs_to_th;
      default:                  w_th = '0;
    endcase
  end

  rx_stage_timer #(.CNT_W(CNT_W)) u_timer (
    .clock (clock),
    .reset (reset),
    .clr   (state_d != state_q),
    .inc   (sample_in_strobe),
    .th    (w_th),
    .hit   (w_to_hit)
  );

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    sym_d       = sym_q;
    n_d         = n_q;
    rcnt_d      = '0;
    done_d      = 1'b0;
    w_fail      = 1'b0;
    w_fail_code = RX_NONE;
    w_sym_next  = sym_inc(sym_q, ofdm_symbol_eq_out_pulse);

    // Every branch tests its qualifying strobe before the timeout so the
    // strobe wins a same-cycle tie.
    case (state_q)
      ST_IDLE: begin
        if (w_start) begin
          state_d = ST_WAIT_LTF;
          sym_d   = '0;
        end
      end
      ST_WAIT_LTF: begin
        if (long_preamble_detected) state_d = ST_WAIT_SIG;
        else if (w_to_hit) begin w_fail = 1'b1; w_fail_code = RX_TO_LTF; end
      end
      ST_WAIT_SIG: begin
        if (pkt_header_valid_strobe) begin
          if (!pkt_header_valid)  begin w_fail = 1'b1; w_fail_code = RX_HDR_ERR; end
          else if (ht_unsupport)  begin w_fail = 1'b1; w_fail_code = RX_UNSUPP; end
          else                    state_d = ST_WAIT_LEN;
        end else if (w_to_hit) begin
          w_fail = 1'b1; w_fail_code = RX_TO_SIG;
        end
      end
      ST_WAIT_LEN: begin
        if (phy_len_valid) begin
          n_d     = n_ofdm_sym;
          state_d = (n_ofdm_sym == 15'd0) ? ST_WAIT_FCS : ST_DECODE;
        end else if (w_to_hit) begin
          w_fail = 1'b1; w_fail_code = RX_TO_SIG;
        end
      end
      ST_DECODE, ST_WAIT_FCS: begin
        sym_d = w_sym_next;
        if (fcs_out_strobe) begin
          state_d  = ST_IDLE;
          status_d = fcs_ok ? RX_OK : RX_FCS_ERR;
          done_d   = 1'b1;
        end else if (state_q == ST_DECODE) begin
          if (w_sym_next >= n_q) state_d = ST_WAIT_FCS;
        end else if (({1'b0, w_sym_next} > w_sym_lim) || w_to_hit) begin
          w_fail = 1'b1; w_fail_code = RX_TO_DATA;
        end
      end
      ST_RST: begin
        if (rcnt_q == RCW'(RST_CYC - 1)) state_d = ST_IDLE;
        else                             rcnt_d  = rcnt_q + RCW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_fail) begin
      state_d  = ST_RST;
      status_d = w_fail_code;
      done_d   = 1'b1;
    end

    core_rst_d = (state_d == ST_RST);
    active_d   = (state_d != ST_IDLE) && (state_d != ST_RST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      status_q   <= RX_NONE;
      spd_q      <= 1'b0;
      sym_q      <= '0;
      n_q        <= '0;
      rcnt_q     <= '0;
      done_q     <= 1'b0;
      core_rst_q <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      spd_q      <= short_preamble_detected;
      sym_q      <= sym_d;
      n_q        <= n_d;
      rcnt_q     <= rcnt_d;
      done_q     <= done_d;
      core_rst_q <= core_rst_d;
      active_q   <= active_d;
    end
  end

  assign core_rst       = core_rst_q;
  assign session_active = active_q;
  assign state          = state_q;
  assign sym_count      = sym_q;
  assign rx_done_strobe = done_q;
  assign rx_status      = status_q;

`ifdef RX_SESSION_CTRL_STAT_EN
  logic [STAT_W-1:0] stat_ok_q, stat_ok_d, stat_fcs_q, stat_fcs_d;
  logic [STAT_W-1:0] stat_hdr_q, stat_hdr_d, stat_to_q, stat_to_d;

  always_comb begin
    stat_ok_d  = stat_ok_q;
    stat_fcs_d = stat_fcs_q;
    stat_hdr_d = stat_hdr_q;
    stat_to_d  = stat_to_q;
    if (done_d) begin
      case (status_d)
        RX_OK:                             stat_ok_d  = stat_ok_q  + STAT_W'(1);
        RX_FCS_ERR:                        stat_fcs_d = stat_fcs_q + STAT_W'(1);
        RX_HDR_ERR, RX_UNSUPP:             stat_hdr_d = stat_hdr_q + STAT_W'(1);
        RX_TO_LTF, RX_TO_SIG, RX_TO_DATA:  stat_to_d  = stat_to_q  + STAT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_ok_q  <= '0;
      stat_fcs_q <= '0;
      stat_hdr_q <= '0;
      stat_to_q  <= '0;
    end else begin
      stat_ok_q  <= stat_ok_d;
      stat_fcs_q <= stat_fcs_d;
      stat_hdr_q <= stat_hdr_d;
      stat_to_q  <= stat_to_d;
    end
  end

  assign stat_ok      = stat_ok_q;
  assign stat_fcs_err = stat_fcs_q;
  assign stat_hdr_err = stat_hdr_q;
  assign stat_timeout = stat_to_q;
`else
  assign stat_ok      = '0;
  assign stat_fcs_err = '0;
  assign stat_hdr_err = '0;
  assign stat_timeout = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_session_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rx_session_ctrl                                                   |
// | Packet-level bench: directed table plus randomized sessions.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rx_session_ctrl;

  localparam int CNT_W      = 16;
  localparam int RST_CYC    = 4;
  localparam int SYM_MARGIN = 2;
  localparam int STAT_W     = 32;
`ifdef RX_SESSION_CTRL_STAT_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ctrl_enable = 1'b1, sample_in_strobe = 1'b0, short_preamble_detected = 1'b0;
  logic long_preamble_detected = 1'b0, pkt_header_valid_strobe = 1'b0, pkt_header_valid = 1'b0;
  logic ht_unsupport = 1'b0, phy_len_valid = 1'b0, ofdm_symbol_eq_out_pulse = 1'b0;
  logic fcs_out_strobe = 1'b0, fcs_ok = 1'b0;
  logic [14:0] n_ofdm_sym = '0;
  logic [CNT_W-1:0] ltf_to_th = '0, sig_to_th = '0, fcs_to_th = '0;
  logic core_rst, session_active, rx_done_strobe;
  logic [2:0] state, rx_status;
  logic [14:0] sym_count;
  logic [STAT_W-1:0] stat_ok, stat_fcs_err, stat_hdr_err, stat_timeout;

  rx_session_ctrl #(.CNT_W(CNT_W), .RST_CYC(RST_CYC), .SYM_MARGIN(SYM_MARGIN), .STAT_W(STAT_W)) dut (
    .clock(clock), .reset(reset), .ctrl_enable(ctrl_enable), .sample_in_strobe(sample_in_strobe),
    .short_preamble_detected(short_preamble_detected), .long_preamble_detected(long_preamble_detected),
    .pkt_header_valid_strobe(pkt_header_valid_strobe), .pkt_header_valid(pkt_header_valid),
    .ht_unsupport(ht_unsupport), .phy_len_valid(phy_len_valid), .n_ofdm_sym(n_ofdm_sym),
    .ofdm_symbol_eq_out_pulse(ofdm_symbol_eq_out_pulse), .fcs_out_strobe(fcs_out_strobe), .fcs_ok(fcs_ok),
    .ltf_to_th(ltf_to_th), .sig_to_th(sig_to_th), .fcs_to_th(fcs_to_th),
    .core_rst(core_rst), .session_active(session_active), .state(state), .sym_count(sym_count),
    .rx_done_strobe(rx_done_strobe), .rx_status(rx_status),
    .stat_ok(stat_ok), .stat_fcs_err(stat_fcs_err), .stat_hdr_err(stat_hdr_err), .stat_timeout(stat_timeout)
  );

  always #5 clock = ~clock;

  // hdr: 0 = never sent, 1 = good, 2 = parity error, 3 = unsupported HT
  typedef struct {
    bit send_ltf; int hdr; bit send_len; int n; int n_eq;
    bit send_fcs; bit fcs_good; bit coinc; bit drop_en;
    int ltf_th; int sig_th; int fcs_th;
    int exp_status;
  } pkt_t;

  int total = 0, bad = 0;
  int done_cnt, rst_cyc, last_status;
  int exp_ok = 0, exp_fcs = 0, exp_hdr = 0, exp_to = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    if (rx_done_strobe) begin done_cnt++; last_status = int'(rx_status); end
    if (core_rst) rst_cyc++;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) tick();
  endtask

  function automatic pkt_t mk(bit l, int h, bit ln, int n, int ne, bit f, bit fo, bit co, bit de,
                              int lt, int st, int ft, int ex);
    pkt_t p;
    p.send_ltf = l; p.hdr = h; p.send_len = ln; p.n = n; p.n_eq = ne;
    p.send_fcs = f; p.fcs_good = fo; p.coinc = co; p.drop_en = de;
    p.ltf_th = lt; p.sig_th = st; p.fcs_th = ft; p.exp_status = ex;
    return p;
  endfunction

  // Outcome of a scripted session, straight from the protocol rules.
  function automatic int model_status(input pkt_t p);
    if (!p.send_ltf)                 return (p.ltf_th != 0) ? 5 : 0;
    if (p.hdr == 0)                  return (p.sig_th != 0) ? 6 : 0;
    if (p.hdr == 2)                  return 3;
    if (p.hdr == 3)                  return 4;
    if (!p.send_len)                 return (p.sig_th != 0) ? 6 : 0;
    if (p.n_eq > p.n + SYM_MARGIN)   return 7;
    if (p.send_fcs)                  return p.fcs_good ? 1 : 2;
    if (p.n_eq >= p.n)               return (p.fcs_th != 0) ? 7 : 0;
    return 0;
  endfunction

  task automatic run_pkt(input pkt_t p, input string tag);
    int  stuck_th, samples, exp_sym;
    bit  stuck, eq_phase;
    done_cnt = 0; rst_cyc = 0; last_status = 0; samples = 0; stuck = 0; stuck_th = 0;
    eq_phase = p.send_ltf && (p.hdr == 1) && p.send_len;
    ltf_to_th = CNT_W'(p.ltf_th); sig_to_th = CNT_W'(p.sig_th); fcs_to_th = CNT_W'(p.fcs_th);
    short_preamble_detected = 1'b1; tick(); short_preamble_detected = 1'b0;
    if (p.drop_en) ctrl_enable = 1'b0;
    gap();
    if (!p.send_ltf) begin
      stuck = 1; stuck_th = p.ltf_th;
    end else begin
      long_preamble_detected = 1'b1; tick(); long_preamble_detected = 1'b0;
      gap();
      if (p.hdr == 0) begin
        stuck = 1; stuck_th = p.sig_th;
      end else begin
        pkt_header_valid_strobe = 1'b1; pkt_header_valid = (p.hdr != 2); ht_unsupport = (p.hdr == 3);
        tick();
        pkt_header_valid_strobe = 1'b0; pkt_header_valid = 1'b0; ht_unsupport = 1'b0;
        if (p.hdr == 1) begin
          gap();
          if (!p.send_len) begin
            stuck = 1; stuck_th = p.sig_th;
          end else begin
            phy_len_valid = 1'b1; n_ofdm_sym = 15'(p.n); tick(); phy_len_valid = 1'b0;
            check({tag, "/len_state"}, state, (p.n == 0) ? 5 : 4);
            for (int i = 0; i < p.n_eq && done_cnt == 0; i++) begin
              ofdm_symbol_eq_out_pulse = 1'b1; tick(); ofdm_symbol_eq_out_pulse = 1'b0;
              if (done_cnt == 0) gap();
            end
            if (done_cnt == 0) begin
              if (p.send_fcs) begin
                if (p.coinc) repeat (p.fcs_th - 1) begin sample_in_strobe = 1'b1; tick(); end
                fcs_out_strobe = 1'b1; fcs_ok = p.fcs_good; sample_in_strobe = p.coinc;
                tick();
                fcs_out_strobe = 1'b0; fcs_ok = 1'b0; sample_in_strobe = 1'b0;
              end else begin
                stuck = 1; stuck_th = p.fcs_th;
              end
            end
          end
        end
      end
    end
    if (stuck) begin
      for (int i = 1; i <= 60; i++) begin
        sample_in_strobe = 1'b1; tick();
        if (done_cnt != 0) begin samples = i; break; end
      end
      sample_in_strobe = 1'b0;
    end

    check({tag, "/status"}, last_status, p.exp_status);
    if (stuck && p.exp_status != 0) check({tag, "/samples_to_timeout"}, samples, stuck_th);
    exp_sym = eq_phase ? ((p.n_eq < p.n + SYM_MARGIN + 1) ? p.n_eq : p.n + SYM_MARGIN + 1) : 0;
    check({tag, "/sym_count"}, sym_count, exp_sym);

    if (p.exp_status != 0) begin
      case (p.exp_status)
        1: exp_ok++;
        2: exp_fcs++;
        3, 4: exp_hdr++;
        default: exp_to++;
      endcase
      // A start edge while the receiver reset is running must be ignored.
      if (p.exp_status >= 3) short_preamble_detected = 1'b1;
      repeat (RST_CYC + 3) tick();
      short_preamble_detected = 1'b0;
      check({tag, "/core_rst_cycles"}, rst_cyc, (p.exp_status >= 3) ? RST_CYC : 0);
      check({tag, "/end_state"}, state, 0);
    end else begin
      check({tag, "/still_active"}, session_active, 1);
      #2 reset = 1'b1;
      #1;
      check({tag, "/rst_state"}, state, 0);
      check({tag, "/rst_outs"}, {core_rst, session_active, rx_done_strobe, rx_status}, 0);
      check({tag, "/rst_sym"}, sym_count, 0);
      tick();
      reset = 1'b0;
      exp_ok = 0; exp_fcs = 0; exp_hdr = 0; exp_to = 0;
      check({tag, "/rst_cycles"}, rst_cyc, 0);
    end
    check({tag, "/done_count"}, done_cnt, (p.exp_status != 0) ? 1 : 0);
    check({tag, "/stat_ok"},      stat_ok,      STAT_EN ? exp_ok  : 0);
    check({tag, "/stat_fcs_err"}, stat_fcs_err, STAT_EN ? exp_fcs : 0);
    check({tag, "/stat_hdr_err"}, stat_hdr_err, STAT_EN ? exp_hdr : 0);
    check({tag, "/stat_timeout"}, stat_timeout, STAT_EN ? exp_to  : 0);
    ctrl_enable = 1'b1;
    tick();
  endtask

  pkt_t tbl[14];

  initial begin
    pkt_t p;
    //            ltf hdr len  n ne fcs ok co de  ltf sig fcs  exp
    tbl[0]  = mk(1, 1, 1, 5, 5, 1, 1, 0, 0, 50, 50, 50, 1);
    tbl[1]  = mk(1, 1, 1, 5, 5, 1, 0, 0, 0, 50, 50, 50, 2);
    tbl[2]  = mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 50, 50, 50, 3);
    tbl[3]  = mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 50, 50, 50, 4);
    tbl[4]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 20, 50, 50, 5);
    tbl[5]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0,  0, 50, 50, 0);
    tbl[6]  = mk(1, 1, 1, 3, 6, 0, 0, 0, 0, 50, 50, 50, 7);
    tbl[7]  = mk(1, 1, 1, 2, 2, 1, 1, 1, 0, 50, 50,  3, 1);
    tbl[8]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 50, 50,  7, 7);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 50,  9, 50, 6);
    tbl[10] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 50,  5, 50, 6);
    tbl[11] = mk(1, 1, 1, 6, 2, 1, 1, 0, 0, 50, 50, 50, 1);
    tbl[12] = mk(1, 1, 1, 4, 2, 0, 0, 0, 0, 50, 50, 50, 0);
    tbl[13] = mk(1, 1, 1, 3, 3, 1, 1, 0, 1, 50, 50, 50, 1);

    repeat (2) tick();
    check("reset/state", state, 0);
    check("reset/core_rst", core_rst, 0);
    check("reset/session_active", session_active, 0);
    check("reset/done", rx_done_strobe, 0);
    check("reset/status", rx_status, 0);
    check("reset/sym_count", sym_count, 0);
    check("reset/stats", stat_ok | stat_fcs_err | stat_hdr_err | stat_timeout, 0);
    reset = 1'b0;
    tick();

    ctrl_enable = 1'b0; short_preamble_detected = 1'b1;
    repeat (3) tick();
    check("disabled/state", state, 0);
    check("disabled/session_active", session_active, 0);
    short_preamble_detected = 1'b0; ctrl_enable = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) run_pkt(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      p.send_ltf = ($urandom % 8) != 0;
      case ($urandom % 10)
        0: p.hdr = 0;
        1: p.hdr = 2;
        2: p.hdr = 3;
        default: p.hdr = 1;
      endcase
      p.send_len = ($urandom % 8) != 0;
      p.n        = $urandom_range(0, 6);
      p.n_eq     = $urandom_range(0, 10);
      p.send_fcs = ($urandom % 4) != 0;
      p.fcs_good = $urandom_range(0, 1) == 1;
      p.coinc    = 1'b0;
      p.drop_en  = $urandom_range(0, 1) == 1;
      p.ltf_th   = (($urandom % 5) == 0) ? 0 : $urandom_range(1, 40);
      p.sig_th   = (($urandom % 5) == 0) ? 0 : $urandom_range(1, 40);
      p.fcs_th   = (($urandom % 5) == 0) ? 0 : $urandom_range(1, 40);
      p.exp_status = model_status(p);
      run_pkt(p, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
